pcie_tx_scheduler: RTL

Arbitrates the single PHY transmit path between three requesters:
- LTSSM ordered-set requests.
- Periodic SKP ordered-set insertion.
- The datalink AXIS packet stream.

The block sits between pcie_datalink_layer/pcie_ltssm_downstream and phy_transmit. It guarantees that packets are never split by ordered sets and that SKP sets are scheduled at a fixed interval while the link is up.

---
 rtl/pcie_tx_scheduler.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pcie_tx_scheduler.sv
// pcie_tx_scheduler: arbitrates the PHY transmit path between LTSSM ordered
// sets, periodic SKP ordered sets and the datalink AXIS packet stream.
// Optional statistics counters: define PCIE_TX_SCHED_STATS_EN.
module pcie_tx_scheduler #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH   = 5,
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_PEND_MAX = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  link_up_i,
  input  logic                  ltssm_os_req_i,
  output logic                  ltssm_os_ack_o,
  output logic                  send_os_o,
  output logic                  os_sel_o,
  input  logic                  os_done_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  skp_overflow_o,
  output logic [2:0]            sched_state_o,
  output logic [15:0]           skp_sent_cnt_o,
  output logic [15:0]           pkt_cnt_o,
  output logic [15:0]           drop_cnt_o
);

  localparam int unsigned CNT_W  = $clog2(SKP_INTERVAL);
  localparam int unsigned PEND_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LTSSM_OS = 3'd1,
    ST_SKP      = 3'd2,
    ST_DATA     = 3'd3,
    ST_DRAIN    = 3'd4
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    skp_cnt;
  logic [PEND_W-1:0]   skp_pend;
  logic                skp_tick;
  logic                skp_done;
  logic                data_last;
  logic                data_to_drain;

  assign skp_tick      = link_up_i && (skp_cnt == CNT_W'(SKP_INTERVAL - 1));
  assign skp_done      = (state == ST_SKP) && os_done_i;
  assign data_last     = (state == ST_DATA) && s_axis_tvalid && m_axis_tready && s_axis_tlast;
  assign data_to_drain = (state == ST_DATA) && !data_last && !link_up_i;

  assign sched_state_o = state;
  // Ack is qualified by the registered state so it pulses with os_done_i.
  assign ltssm_os_ack_o = (state == ST_LTSSM_OS) && os_done_i;

  // SKP interval timer and pending-request counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      skp_cnt        <= '0;
      skp_pend       <= '0;
      skp_overflow_o <= 1'b0;
    end else begin
      skp_overflow_o <= 1'b0;
      if (!link_up_i) begin
        skp_cnt  <= '0;
        skp_pend <= '0;
      end else begin
        skp_cnt <= skp_tick ? '0 : skp_cnt + CNT_W'(1);
        if (skp_tick && skp_done) begin
          skp_pend <= skp_pend;
        end else if (skp_tick) begin
          if (skp_pend < PEND_W'(SKP_PEND_MAX)) begin
            skp_pend <= skp_pend + PEND_W'(1);
          end else begin
            skp_overflow_o <= 1'b1;
          end
        end else if (skp_done && (skp_pend != '0)) begin
          skp_pend <= skp_pend - PEND_W'(1);
        end
      end
    end
  end

  // Scheduler FSM with registered ordered-set command outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      send_os_o <= 1'b0;
      os_sel_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ltssm_os_req_i) begin
            state     <= ST_LTSSM_OS;
            send_os_o <= 1'b1;
            os_sel_o  <= 1'b0;
          end else if ((skp_pend != '0) && link_up_i) begin
            state     <= ST_SKP;
            send_os_o <= 1'b1;
            os_sel_o  <= 1'b1;
          end else if (s_axis_tvalid && link_up_i) begin
            state <= ST_DATA;
          end
        end
        ST_LTSSM_OS: begin
          if (os_done_i) begin
            state     <= ST_IDLE;
            send_os_o <= 1'b0;
          end
        end
        ST_SKP: begin
          if (os_done_i) begin
            state     <= ST_IDLE;
            send_os_o <= 1'b0;
            os_sel_o  <= 1'b0;
          end
        end
        ST_DATA: begin
          if (data_last) begin
            state <= ST_IDLE;
          end else if (!link_up_i) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          send_os_o <= 1'b0;
          os_sel_o  <= 1'b0;
        end
      endcase
    end
  end

  // AXIS pass-through in DATA, sink-and-discard in DRAIN, quiet otherwise
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    s_axis_tready = 1'b0;
    if (state == ST_DATA) begin
      m_axis_tdata  = s_axis_tdata;
      m_axis_tkeep  = s_axis_tkeep;
      m_axis_tvalid = s_axis_tvalid;
      m_axis_tlast  = s_axis_tlast;
      m_axis_tuser  = s_axis_tuser;
      s_axis_tready = m_axis_tready;
    end else if (state == ST_DRAIN) begin
      s_axis_tready = 1'b1;
    end
  end

`ifdef PCIE_TX_SCHED_STATS_EN
  logic [15:0] skp_sent_q;
  logic [15:0] pkt_q;
  logic [15:0] drop_q;

  // Saturating event counters
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      skp_sent_q <= '0;
      pkt_q      <= '0;
      drop_q     <= '0;
    end else begin
      if (skp_done && (skp_sent_q != 16'hFFFF)) begin
        skp_sent_q <= skp_sent_q + 16'd1;
      end
      if (data_last && (pkt_q != 16'hFFFF)) begin
        pkt_q <= pkt_q + 16'd1;
      end
      if (data_to_drain && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign skp_sent_cnt_o = skp_sent_q;
  assign pkt_cnt_o      = pkt_q;
  assign drop_cnt_o     = drop_q;
`else
  assign skp_sent_cnt_o = 16'd0;
  assign pkt_cnt_o      = 16'd0;
  assign drop_cnt_o     = 16'd0;
`endif

endmodule
